// File: rtl/sipo_pkg.sv
// Purpose : shared types and helpers for the sipo_rx serial frame receiver.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, STATE_W, cnt_w() bit-counter width helper.
package sipo_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   // Counter width needed to count WIDTH data bits (minimum one bit).
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Purpose : data shift register plus data-bit counter for sipo_rx.
// Latency : one bit per enabled clk; last_bit is combinational from the counter.
// Backpressure: none; the shift is driven purely by shift_en.
// Ports   : clk, rst (async, active-high), clr (restart bit count), shift_en,
//           si (serial bit), sr (assembled word), last_bit (current shift is the final data bit).
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             si,
   output logic [WIDTH-1:0] sr,
   output logic             last_bit
);

   localparam int CNT_W = cnt_w(WIDTH);

   logic [CNT_W-1:0] cnt;

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (shift_en) begin
         // Wrap explicitly so non-power-of-two widths restart cleanly.
         cnt <= last_bit ? '0 : cnt + CNT_W'(1);
         if (MSB_FIRST) begin
            sr <= {sr[WIDTH-2:0], si};
         end else begin
            sr <= {si, sr[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/sipo_rx.sv
// Purpose : serial-to-parallel frame receiver (start bit, WIDTH data bits, optional parity).
// Latency : dout_valid rises WIDTH+1 clk after the start bit is sampled (WIDTH+2 with parity).
// Backpressure: one-word output register held until dout_ready; a word completing while the
//               register is full and not being accepted is dropped with a one-cycle overrun pulse.
// Ports   : clk, rst (async, active-high), si, dout/dout_valid/dout_ready, dout_perr, overrun, busy.
// Config  : define SIPO_PARITY_EN to add an even-parity bit after the data bits.
module sipo_rx
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_perr,
   output logic             overrun,
   output logic             busy
);

   state_t           state_q;
   state_t           state_d;
   logic             start;
   logic             shift_en;
   logic             last_bit;
   logic             word_done_d;
   logic             word_done_q;
   logic             load;
   logic [WIDTH-1:0] sr;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .clr      (start),
      .shift_en (shift_en),
      .si       (si),
      .sr       (sr),
      .last_bit (last_bit)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (si) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
`ifdef SIPO_PARITY_EN
               state_d = PARITY;
`else
               state_d = IDLE;
`endif
            end
         end
         PARITY: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy        = (state_q != IDLE);
      start       = (state_q == IDLE) && si;
      shift_en    = (state_q == SHIFT);
`ifdef SIPO_PARITY_EN
      word_done_d = (state_q == PARITY);
`else
      word_done_d = (state_q == SHIFT) && last_bit;
`endif
   end

   // Word-complete is registered so the output register loads the cycle after the
   // final frame bit; sr cannot change in that cycle because a new frame's first
   // data bit is at least one cycle behind its start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_done_q <= 1'b0;
      end else begin
         word_done_q <= word_done_d;
      end
   end

   assign load = word_done_q && (!dout_valid || dout_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= word_done_q && !load;
         if (load) begin
            dout       <= sr;
            dout_valid <= 1'b1;
         end else if (!word_done_q && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

`ifdef SIPO_PARITY_EN
   // Running XOR over data and parity bits; nonzero at frame end means odd parity.
   logic par_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_acc <= 1'b0;
      end else if (start) begin
         par_acc <= 1'b0;
      end else if ((state_q == SHIFT) || (state_q == PARITY)) begin
         par_acc <= par_acc ^ si;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_perr <= 1'b0;
      end else if (load) begin
         dout_perr <= par_acc;
      end
   end
`else
   assign dout_perr = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;

   localparam int W = 4;
`ifdef SIPO_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = W + 1 + PAR;   // frame length in bits

   typedef struct {
      int           edge_no;
      logic [W-1:0] w_msb;
      logic [W-1:0] w_lsb;
      bit           perr;
   } pend_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         si = 1'b0;
   logic         dout_ready = 1'b0;
   logic [W-1:0] dout_m, dout_l;
   logic         dout_valid_m, dout_valid_l;
   logic         dout_perr_m, dout_perr_l;
   logic         overrun_m, overrun_l;
   logic         busy_m, busy_l;

   int n_cmp = 0;
   int n_fail = 0;
   int edge_idx = 0;    // index of the upcoming rising edge
   bit full = 1'b0;     // model: output register holds a word (after the upcoming edge)
   bit vis_full = 1'b0; // model: output register state currently visible

   pend_t        pend_q[$];
   logic [W:0]   exp_m[$];
   logic [W:0]   exp_l[$];
   int           ovr_qm[$];
   int           ovr_ql[$];

   always #5 clk = ~clk;

   sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .si(si), .dout(dout_m), .dout_valid(dout_valid_m),
      .dout_ready(dout_ready), .dout_perr(dout_perr_m), .overrun(overrun_m), .busy(busy_m)
   );

   sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .si(si), .dout(dout_l), .dout_valid(dout_valid_l),
      .dout_ready(dout_ready), .dout_perr(dout_perr_l), .overrun(overrun_l), .busy(busy_l)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_idx);
      end
   endtask

   // One clock of stimulus, driven on the falling edge. The model then decides what
   // the upcoming rising edge does to the output register.
   task automatic tick(input bit si_v, input int rmode, input bit rst_v);
      bit rdy;
      pend_t p;
      @(negedge clk);
      edge_idx++;
      rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode != 0);
      si = si_v;
      dout_ready = rdy;
      rst = rst_v;
      if (rst_v) begin
         pend_q.delete();
         full = 1'b0;
         vis_full = 1'b0;
      end else begin
         vis_full = full;
         if (pend_q.size() > 0 && pend_q[0].edge_no == edge_idx) begin
            p = pend_q.pop_front();
            if (!full || rdy) begin
               exp_m.push_back({p.perr, p.w_msb});
               exp_l.push_back({p.perr, p.w_lsb});
               full = 1'b1;
            end else begin
               ovr_qm.push_back(edge_idx);
               ovr_ql.push_back(edge_idx);
            end
         end else if (full && rdy) begin
            full = 1'b0;
         end
      end
   endtask

   // d[i] is the i-th data bit on the wire.
   task automatic send_frame(input logic [W-1:0] d, input bit bad_par, input int rmode);
      pend_t p;
      logic  par;
      for (int i = 0; i < W; i++) begin
         p.w_msb[W-1-i] = d[i];
         p.w_lsb[i]     = d[i];
      end
      p.edge_no = edge_idx + 1 + FL;   // start at edge_idx+1, load one edge after last bit
      p.perr    = (PAR != 0) ? bad_par : 1'b0;
      par       = (^d) ^ bad_par;
      pend_q.push_back(p);
      tick(1'b1, rmode, 1'b0);
      for (int i = 0; i < W; i++) tick(d[i], rmode, 1'b0);
      if (PAR != 0) tick(par, rmode, 1'b0);
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) tick(1'b0, rmode, 1'b0);
   endtask

   // Monitor: checks what the next rising edge will see, 1 time unit after stimulus.
   always @(negedge clk) begin
      logic [W:0] e;
      int k;
      #1;
      if (!rst) begin
         chk("valid_msb", dout_valid_m, vis_full);
         chk("valid_lsb", dout_valid_l, vis_full);
         if (overrun_m) begin
            if (ovr_qm.size() == 0) chk("overrun_msb_unexpected", 1, 0);
            else begin k = ovr_qm.pop_front(); chk("overrun_msb_edge", edge_idx - 1, k); end
         end
         if (overrun_l) begin
            if (ovr_ql.size() == 0) chk("overrun_lsb_unexpected", 1, 0);
            else begin k = ovr_ql.pop_front(); chk("overrun_lsb_edge", edge_idx - 1, k); end
         end
         if (dout_valid_m && dout_ready) begin
            if (exp_m.size() == 0) chk("word_msb_unexpected", 1, 0);
            else begin e = exp_m.pop_front(); chk("word_msb", {dout_perr_m, dout_m}, e); end
         end
         if (dout_valid_l && dout_ready) begin
            if (exp_l.size() == 0) chk("word_lsb_unexpected", 1, 0);
            else begin e = exp_l.pop_front(); chk("word_lsb", {dout_perr_l, dout_l}, e); end
         end
      end
   end

   initial begin
      // Reset and idle line.
      tick(1'b0, 0, 1'b1);
      tick(1'b0, 0, 1'b1);
      idle(5, 0);
      #2;
      chk("rst_busy_msb", busy_m, 0);
      chk("rst_busy_lsb", busy_l, 0);
      chk("rst_dout_msb", dout_m, 0);
      chk("rst_dout_lsb", dout_l, 0);
      chk("rst_perr", dout_perr_m, 0);
      chk("rst_overrun", overrun_m, 0);

      // Reset mid-frame: start + two data bits, then abort.
      tick(1'b1, 1, 1'b0);
      tick(1'b1, 1, 1'b0);
      tick(1'b0, 1, 1'b0);
      tick(1'b0, 1, 1'b1);
      idle(1, 1);
      send_frame(4'b1110, 1'b0, 1);   // wire order 0,1,1,1
      idle(3, 1);
      #2;
      chk("abort_dout_msb", dout_m, 4'b0111);
      chk("abort_dout_lsb", dout_l, 4'b1110);

      // Single frame, consumer always ready: wire 1,0,1,1.
      send_frame(4'b1101, 1'b0, 1);
      idle(3, 1);
      #2;
      chk("single_dout_msb", dout_m, 4'b1011);
      chk("single_dout_lsb", dout_l, 4'b1101);
      chk("single_busy", busy_m, 0);

      // Back-to-back with consumer stalled: first held, second dropped.
      send_frame(4'b1001, 1'b0, 0);   // wire 1,0,0,1
      send_frame(4'b0110, 1'b0, 0);   // wire 0,1,1,0
      idle(4, 0);
      #2;
      chk("stall_dout_msb", dout_m, 4'b1001);
      chk("stall_valid_msb", dout_valid_m, 1);
      idle(3, 1);

`ifdef SIPO_PARITY_EN
      send_frame(4'b1101, 1'b0, 1);
      idle(2, 1);
      send_frame(4'b1101, 1'b1, 1);
      idle(2, 0);
      #2;
      chk("par_dout_msb", dout_m, 4'b1011);
      chk("par_perr_msb", dout_perr_m, 1);
      idle(2, 1);
`endif

      // Randomized frames, gaps and consumer behaviour.
      for (int f = 0; f < 60; f++) begin
         int rm;
         rm = int'($urandom_range(0, 3));
         if (rm == 3) rm = 2;
         send_frame(W'($urandom), ($urandom_range(0, 3) == 0), rm);
         idle(int'($urandom_range(0, 3)), rm);
      end

      idle(20, 1);
      #2;
      chk("left_exp_msb", exp_m.size(), 0);
      chk("left_exp_lsb", exp_l.size(), 0);
      chk("left_ovr_msb", ovr_qm.size(), 0);
      chk("left_ovr_lsb", ovr_ql.size(), 0);
      chk("left_pend", pend_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
